fifo_umbral: RTL
================

# fifo_umbral

Synchronous FIFO with programmable almost-empty/almost-full thresholds and overflow/underflow error reporting. It is the per-queue buffer whose `empty` and `error` flags feed the control state machine's `FIFO_empties`/`FIFO_errors` vectors. One instance per queue: five instances give the 5-bit vectors. Threshold inputs are driven from the state machine's latched `Umbrales_*_internos` outputs.

## Interface
- `DATA_W`, default 6: data word width.
- `ADDR_W`, default 2: address width; depth = 2**ADDR_W (default 4 entries).
- `clk`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: asynchronous, active-low; 0 clears all state immediately.
- `umbral_bajo`  in  ADDR_W: almost-empty threshold, live, not latched.
- `umbral_alto`  in  ADDR_W: almost-full threshold, live; 0 disables almost_full.
- `push`  in  1: write request, data_in sampled on same edge.
- `data_in`  in  DATA_W: write data.
- `pop`  in  1: read request.
- `data_out`  out  DATA_W: registered read data.
- `valid_out`  out  1: data_out holds a word popped on the previous edge.
- `count`  out  ADDR_W+1: current occupancy, 0..2**ADDR_W.
- `empty`  out  1: count == 0.
- `full`  out  1: count == 2**ADDR_W.
- `almost_empty`  out  1: count <= umbral_bajo.
- `almost_full`  out  1: umbral_alto != 0 and count >= umbral_alto.
- `error`  out  1: one-cycle pulse after an overflow or underflow attempt.

## Operation
- Storage: circular buffer with write pointer `wr_ptr` and read pointer `rd_ptr`, both ADDR_W bits, wrapping modulo 2**ADDR_W. A separate `count` register tracks occupancy.
- Push accepted when `!full`, or when `full && pop` (simultaneous read frees the slot). Accepted push writes `mem[wr_ptr]` and increments wr_ptr.
- Pop accepted when `!empty`. Accepted pop registers `mem[rd_ptr]` into data_out, sets valid_out=1 and increments rd_ptr. Any edge without an accepted pop sets valid_out=0; data_out holds its last value.
- Count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Overflow: push while full with no pop. The word is dropped, pointers and count are unchanged, and error=1 on the next cycle.
- Underflow: pop while empty. Nothing is read and valid_out=0. If push is also high, the push is still accepted (count becomes 1) and error=1 on the next cycle.
- Push and pop on an empty FIFO: pop is rejected (underflow), so data is not bypassed.
- Push and pop on a full FIFO: both are accepted, count stays 2**ADDR_W, no error.
- `empty`, `full`, `almost_*` are combinational from registered count and the live thresholds. Threshold changes take effect in the same cycle.

## Timing
- Reset values (reset=0): wr_ptr=0, rd_ptr=0, count=0, data_out=0, valid_out=0, error=0. Flags: empty=1, full=0, almost_empty=1, almost_full=0 (count 0 ≥ threshold only if umbral_alto=0, which disables it).
- Reset asserted mid-operation clears everything asynchronously and discards stored data. Memory contents need not be cleared.
- Write-to-flag latency: flags reflect a push on the edge after it (count registered).
- Read latency: data_out/valid_out valid 1 cycle after the pop edge.
- Error latency: pulse high exactly 1 cycle after the offending edge, 1 cycle wide per offending edge. Back-to-back violations keep it high.

## Structure
- Shared include file `fifo_defs.vh`: default DATA_W=6, ADDR_W=2. The five-queue vector width (5) is also used by the state machine and bench.
- Sub-module `mem_2p`: dual-port register file, 1 synchronous write port and 1 registered read port, DATA_W × 2**ADDR_W, no reset on the array. Top level holds pointers, count, flags and error logic.

## Test plan
- Reset then push 0x01..0x04 on 4 consecutive edges. Required: count 1,2,3,4; full=1 after the 4th; with umbral_alto=3, almost_full rises after the 3rd push.
- Full FIFO, push 0x3F without pop. Required: error=1 for one cycle, count stays 4, later pops return 0x01..0x04 in order.
- Pop 4 times. Required: data_out 0x01..0x04 each 1 cycle after its pop, valid_out=1 each time, empty=1 after the last. With umbral_bajo=1, almost_empty rises at count=1.
- Pop on empty with push of 0x2A. Required: error pulse, valid_out=0, count=1, next pop returns 0x2A.
- Full FIFO, push and pop together for 3 cycles. Required: count holds 4, no error, wr_ptr/rd_ptr wrap through 0, output order preserved.
- reset=0 asynchronously mid-stream, between edges, with count=2. Required: count=0, empty=1, valid_out=0, error=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/fifo_umbral_pkg.sv
// fifo_umbral shared definitions: default geometry and the per-edge operation code.
// Revision 1.0
`default_nettype none

package fifo_umbral_pkg;

  localparam int DEF_DATA_W = 6;
  localparam int DEF_ADDR_W = 2;

  // Encoded as {pop_accepted, push_accepted}
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e encode_op(input logic push_ok, input logic pop_ok);
    return fifo_op_e'({pop_ok, push_ok});
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_umbral_mem_2p.sv
// Dual-port register file: one synchronous write port, one registered read port.
// Revision 1.0
`default_nettype none

module fifo_umbral_mem_2p #(
  parameter int DATA_W = 6,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register holds its last value when no read is requested
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_umbral.sv
// Synchronous FIFO with live almost-empty/almost-full thresholds and a one-cycle error pulse.
// Revision 1.0
`default_nettype none

module fifo_umbral
  import fifo_umbral_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] umbral_bajo,
  input  logic [ADDR_W-1:0] umbral_alto,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic              error
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push_ok;
  logic              pop_ok;
  logic              violation;
  fifo_op_e          op;

  assign empty        = (count == '0);
  assign full         = (count == DEPTH);
  assign almost_empty = (count <= {1'b0, umbral_bajo});
  assign almost_full  = (umbral_alto != '0) && (count >= {1'b0, umbral_alto});

  // A pop on a full FIFO frees the slot the push lands in; an empty FIFO never bypasses
  assign push_ok   = push && (!full || pop);
  assign pop_ok    = pop && !empty;
  assign violation = (push && full && !pop) || (pop && empty);
  assign op        = encode_op(push_ok, pop_ok);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      valid_out <= 1'b0;
      error     <= 1'b0;
    end else begin
      valid_out <= pop_ok;
      error     <= violation;
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case (op)
        OP_PUSH: count <= count + 1'b1;
        OP_POP:  count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  fifo_umbral_mem_2p #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .reset(reset),
    .we   (push_ok),
    .waddr(wr_ptr),
    .wdata(data_in),
    .re   (pop_ok),
    .raddr(rd_ptr),
    .rdata(data_out)
  );

endmodule

`default_nettype wire
